// File: rtl/versat_dbus_arb.sv
// Round-robin arbiter that funnels N native-bus masters onto one shared L2/external-memory port.
// One transaction is in flight at a time, and there is always one IDLE cycle between grants.
module versat_dbus_arb #(
  parameter int N_MASTERS = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 256
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_MASTERS-1:0]            m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb,
  output logic [N_MASTERS*DATA_W-1:0]     m_rdata,
  output logic [N_MASTERS-1:0]            m_ready,
  output logic                            s_valid,
  output logic [ADDR_W-1:0]               s_addr,
  output logic [DATA_W-1:0]               s_wdata,
  output logic [DATA_W/8-1:0]             s_wstrb,
  input  logic [DATA_W-1:0]               s_rdata,
  input  logic                            s_ready,
  output logic [N_MASTERS-1:0]            grant,
  output logic                            busy
);

  localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;

  logic                 hi_found;
  logic [IDX_W-1:0]     hi_idx, lo_idx, sel_idx;
  logic                 req_held;

  // Round-robin pick: lowest requester at or above ptr, otherwise wrap to the lowest requester overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (m_valid[i]) begin
        lo_idx = IDX_W'(i);
        if (IDX_W'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    sel_idx = hi_found ? hi_idx : lo_idx;
  end

  assign req_held = |(m_valid & grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|m_valid) begin
          state_d          = BUSY;
          idx_d            = sel_idx;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
        end
      end
      BUSY: begin
        // A completion and a requester withdrawing its request both end the transaction.
        // The withdrawal case keeps the arbiter from hanging.
        if (s_ready || !req_held) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (idx_q == IDX_W'(N_MASTERS - 1)) ? '0 : idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  // grant_q is zero outside BUSY, so the shared-port fields fall to zero in IDLE.
  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant_q[i]) begin
        s_addr  = m_addr[i*ADDR_W +: ADDR_W];
        s_wdata = m_wdata[i*DATA_W +: DATA_W];
        s_wstrb = m_wstrb[i*STRB_W +: STRB_W];
      end
    end
  end

  assign s_valid = req_held;
  assign busy    = (state_q == BUSY);
  assign grant   = grant_q;
  assign m_ready = (state_q == BUSY && s_ready) ? grant_q : '0;
  assign m_rdata = {N_MASTERS{s_rdata}};

endmodule

// File: tb/tb_versat_dbus_arb.sv
// Bench for versat_dbus_arb: directed scenarios plus randomized traffic.
// A per-cycle behavioural model predicts the owner and the pointer.
module tb_versat_dbus_arb;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int SW = DW / 8;
  localparam int CW = N * DW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    m_valid = '0;
  logic [N*AW-1:0] m_addr = '0;
  logic [N*DW-1:0] m_wdata = '0;
  logic [N*SW-1:0] m_wstrb = '0;
  logic [N*DW-1:0] m_rdata;
  logic [N-1:0]    m_ready;
  logic            s_valid;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic [DW-1:0]   s_rdata = '0;
  logic            s_ready = 1'b0;
  logic [N-1:0]    grant;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int own = -1;
  int ptr = 0;

  versat_dbus_arb #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] v;
    for (int w = 0; w < DW / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  // Model: own is the master currently holding the port (-1 when idle); ptr is where the next search starts.
  always @(negedge clk) begin
    logic [N-1:0]  eg, em;
    logic          ev;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [SW-1:0] es;
    int            nxt;
    if (!rst_n) begin
      own = -1;
      ptr = 0;
      chk("rst_grant", CW'(grant), '0);
      chk("rst_busy", CW'(busy), '0);
      chk("rst_s_valid", CW'(s_valid), '0);
      chk("rst_m_ready", CW'(m_ready), '0);
    end else begin
      eg = '0; ev = 1'b0; ea = '0; ed = '0; es = '0;
      if (own >= 0) begin
        eg[own] = 1'b1;
        ev = m_valid[own];
        ea = m_addr[own*AW +: AW];
        ed = m_wdata[own*DW +: DW];
        es = m_wstrb[own*SW +: SW];
      end
      em = (own >= 0 && s_ready) ? eg : '0;
      chk("model_grant", CW'(grant), CW'(eg));
      chk("model_busy", CW'(busy), CW'(own >= 0));
      chk("model_s_valid", CW'(s_valid), CW'(ev));
      chk("model_s_addr", CW'(s_addr), CW'(ea));
      chk("model_s_wdata", CW'(s_wdata), CW'(ed));
      chk("model_s_wstrb", CW'(s_wstrb), CW'(es));
      chk("model_m_ready", CW'(m_ready), CW'(em));
      chk("model_m_rdata", m_rdata, {N{s_rdata}});
      if (own < 0) begin
        nxt = -1;
        for (int k = 0; k < N; k++)
          if (nxt < 0 && m_valid[(ptr + k) % N]) nxt = (ptr + k) % N;
        own = nxt;
      end else if (s_ready || !m_valid[own]) begin
        ptr = (own + 1) % N;
        own = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_valid = '0;
    s_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] exp33 [4];
    logic [N-1:0] r;
    exp33[0] = 3'b001; exp33[1] = 3'b010; exp33[2] = 3'b100; exp33[3] = 3'b001;
    for (int i = 0; i < N; i++) begin
      m_addr[i*AW +: AW]  = $urandom;
      m_wdata[i*DW +: DW] = rnd_data();
      m_wstrb[i*SW +: SW] = $urandom;
    end
    do_reset();

    // All three request continuously; s_ready arrives two cycles after each s_valid.
    m_valid = 3'b111;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("rr_grant", CW'(grant), CW'(exp33[t]));
      chk("rr_s_valid", CW'(s_valid), CW'(1'b1));
      tick();
      tick();
      s_ready = 1'b1;
      #1 chk("rr_m_ready", CW'(m_ready), CW'(exp33[t]));
      tick();
      s_ready = 1'b0;
      chk("rr_gap_s_valid", CW'(s_valid), '0);
      chk("rr_gap_m_ready", CW'(m_ready), '0);
      if (t == 3) m_valid = '0;
    end

    // Lone write from master 2.
    do_reset();
    m_addr[2*AW +: AW] = 32'h100;
    m_wstrb[2*SW +: SW] = '1;
    m_valid = 3'b100;
    tick();
    chk("m2_grant", CW'(grant), CW'(3'b100));
    chk("m2_s_valid", CW'(s_valid), CW'(1'b1));
    chk("m2_s_addr", CW'(s_addr), CW'(32'h100));
    chk("m2_s_wstrb", CW'(s_wstrb), CW'({SW{1'b1}}));
    s_ready = 1'b1;
    #1 chk("m2_m_ready", CW'(m_ready), CW'(3'b100));
    tick();
    s_ready = 1'b0;
    m_valid = 3'b111;
    tick();
    chk("m2_ptr_wrap", CW'(grant), CW'(3'b001));
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    m_valid = '0;
    tick();

    // Master 0 requests while master 1 owns the port.
    do_reset();
    m_valid = 3'b010;
    tick();
    chk("np_grant1", CW'(grant), CW'(3'b010));
    m_valid = 3'b011;
    tick();
    chk("np_hold", CW'(grant), CW'(3'b010));
    s_ready = 1'b1;
    #1 chk("np_m_ready", CW'(m_ready), CW'(3'b010));
    tick();
    s_ready = 1'b0;
    m_valid = 3'b001;
    tick();
    chk("np_grant0", CW'(grant), CW'(3'b001));
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    m_valid = '0;
    tick();

    // Read by master 0.
    do_reset();
    m_wstrb[0 +: SW] = '0;
    m_valid = 3'b001;
    tick();
    s_rdata = {{(DW-32){1'b0}}, 32'hDEADBEEF};
    s_ready = 1'b1;
    #1 chk("rd_rdata0", CW'(m_rdata[31:0]), CW'(32'hDEADBEEF));
    chk("rd_m_ready", CW'(m_ready), CW'(3'b001));
    tick();
    s_ready = 1'b0;
    m_valid = '0;
    tick();

    // Reset during BUSY once ptr has moved to 2.
    do_reset();
    m_valid = 3'b010;
    tick();
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    m_valid = 3'b100;
    tick();
    chk("rb_busy_before", CW'(busy), CW'(1'b1));
    rst_n = 1'b0;
    s_ready = 1'b1;
    #1 chk("rb_grant", CW'(grant), '0);
    chk("rb_busy", CW'(busy), '0);
    chk("rb_s_valid", CW'(s_valid), '0);
    chk("rb_m_ready", CW'(m_ready), '0);
    tick();
    s_ready = 1'b0;
    m_valid = 3'b110;
    rst_n = 1'b1;
    tick();
    chk("rb_restart", CW'(grant), CW'(3'b010));
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    m_valid = '0;
    tick();

    // Spurious s_ready while idle, then master 0 withdraws its request mid-transaction.
    do_reset();
    s_ready = 1'b1;
    #1 chk("sp_m_ready", CW'(m_ready), '0);
    chk("sp_busy", CW'(busy), '0);
    tick();
    chk("sp_busy_after", CW'(busy), '0);
    s_ready = 1'b0;
    m_valid = 3'b001;
    tick();
    chk("ab_grant", CW'(grant), CW'(3'b001));
    m_valid = '0;
    #1 chk("ab_s_valid", CW'(s_valid), '0);
    chk("ab_m_ready", CW'(m_ready), '0);
    tick();
    chk("ab_idle_busy", CW'(busy), '0);
    chk("ab_idle_grant", CW'(grant), '0);
    m_valid = 3'b001;
    tick();
    chk("ab_regrant", CW'(grant), CW'(3'b001));
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    m_valid = '0;
    tick();

    // Randomized traffic: requests stay up until ready, with occasional withdrawals and stray s_ready.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r = m_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (m_valid[i]) begin
          if (r[i] || $urandom_range(0, 59) == 0) m_valid[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          m_valid[i] = 1'b1;
          m_addr[i*AW +: AW]  = $urandom;
          m_wdata[i*DW +: DW] = rnd_data();
          m_wstrb[i*SW +: SW] = ($urandom_range(0, 1) == 0) ? '0 : SW'($urandom);
        end
      end
      s_ready = ($urandom_range(0, 2) == 0);
      s_rdata = rnd_data();
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/versat_dbus_arb.md
VERSAT_DBUS_ARB -- requirements
Module: versat_dbus_arb

Interface
REQ-001 Parameter N_MASTERS, default 3, number of requesting native-bus masters (2..8).
REQ-002 Parameter ADDR_W, default 32, request address width.
REQ-003 Parameter DATA_W, default 256, data width; must be a multiple of 8.
REQ-004 Port clk  input  1  single clock; all state on rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port m_valid  input  N_MASTERS  per-master request valid, held until that master's ready.
REQ-007 Port m_addr  input  N_MASTERS*ADDR_W  packed per-master address, master i at slice i.
REQ-008 Port m_wdata  input  N_MASTERS*DATA_W  packed per-master write data.
REQ-009 Port m_wstrb  input  N_MASTERS*DATA_W/8  packed per-master byte strobes; all-zero means read.
REQ-010 Port m_rdata  output  N_MASTERS*DATA_W  packed read data; every slice carries s_rdata.
REQ-011 Port m_ready  output  N_MASTERS  per-master completion pulse.
REQ-012 Port s_valid  output  1  request valid to the shared L2/external-memory port.
REQ-013 Port s_addr, s_wdata, s_wstrb  output  ADDR_W, DATA_W, DATA_W/8  granted master's request fields.
REQ-014 Port s_rdata  input  DATA_W  shared-port read data, valid with s_ready.
REQ-015 Port s_ready  input  1  shared-port completion pulse.
REQ-016 Port grant  output  N_MASTERS  one-hot current owner, all-zero when idle.
REQ-017 Port busy  output  1  high in BUSY state.

Function
REQ-018 FSM has two states, IDLE and BUSY.
REQ-019 In IDLE with any m_valid set, the arbiter selects the first set bit searching upward from pointer ptr with wrap-around, registers grant one-hot, and enters BUSY next cycle.
REQ-020 In IDLE with m_valid all-zero, the FSM stays in IDLE, and grant and ptr hold.
REQ-021 In BUSY, s_valid, s_addr, s_wdata and s_wstrb equal the granted master's m_valid and fields, combinationally.
REQ-022 In IDLE, s_valid is 0 and s_addr/s_wdata/s_wstrb are 0.
REQ-023 m_ready[i] = s_ready AND grant[i] AND BUSY; non-granted masters never see ready.
REQ-024 On s_ready in BUSY: next state IDLE, grant cleared, ptr = (granted index + 1) mod N_MASTERS.
REQ-025 Minimum latency is 1 cycle from m_valid rising in IDLE to s_valid; there is 1 IDLE cycle between back-to-back transactions.
REQ-026 Fairness: a continuously requesting master is granted within N_MASTERS-1 other transactions.
REQ-027 If the granted master drops m_valid in BUSY without s_ready, the FSM aborts to IDLE next cycle and ptr advances as in REQ-024; this is a protocol violation that must not hang the arbiter.
REQ-028 An s_ready in IDLE is ignored: no m_ready and no state change.
REQ-029 New m_valid from other masters during BUSY does not preempt; they are arbitrated at the next IDLE.
REQ-030 grant is one-hot or zero at all times; busy equals |grant.

Reset
REQ-031 While rst_n=0: state IDLE, grant=0, ptr=0, busy=0, s_valid=0, m_ready=0, asynchronously.
REQ-032 Reset asserted mid-transaction discards the transaction; after release, arbitration restarts from master 0.

Verification
REQ-033 After reset, m_valid=3'b111 and s_ready returned 2 cycles after each s_valid -> grant order 001,010,100,001; each m_ready is a single cycle; s_valid is low in each IDLE gap.
REQ-034 Only master 2 requests, write with m_wstrb=all-ones and m_addr=0x100 -> s_valid 1 cycle later, s_addr=0x100, s_wstrb all-ones, m_ready[2] on s_ready, ptr=0 afterwards.
REQ-035 Master 1 busy; master 0 asserts m_valid mid-transaction -> no preemption, m_ready[0]=0, master 0 granted next IDLE.
REQ-036 Read by master 0 with s_rdata=0xDEADBEEF on s_ready -> m_rdata slice 0 = 0xDEADBEEF and m_ready=3'b001.
REQ-037 rst_n pulsed low during BUSY -> all outputs 0 immediately; after release, m_valid=3'b110 -> master 1 granted first.
REQ-038 Spurious s_ready in IDLE, and granted master dropping m_valid in BUSY -> no m_ready, FSM returns to IDLE, no deadlock.
